// File: rtl/round_sequencer_if.sv
// Bundles the game-controller signals. The sequencer uses the master modport and the
// surrounding switches, random source, score path and tone block use the slave modport.
interface round_sequencer_if;
  logic       start;
  logic [1:0] gameMode;
  logic [3:0] userGuess;
  logic [3:0] randValue;
  logic       rand_valid;
  logic       snd_ack;

  logic       rand_req;
  logic [1:0] mode_sel;
  logic       guess_window;
  logic       score_we;
  logic       score_hit;
  logic       snd_req;
  logic       snd_sel;
  logic [3:0] round_num;
  logic       game_done;
  logic       busy;

  modport master (
    input  start, gameMode, userGuess, randValue, rand_valid, snd_ack,
    output rand_req, mode_sel, guess_window, score_we, score_hit,
           snd_req, snd_sel, round_num, game_done, busy
  );

  modport slave (
    output start, gameMode, userGuess, randValue, rand_valid, snd_ack,
    input  rand_req, mode_sel, guess_window, score_we, score_hit,
           snd_req, snd_sel, round_num, game_done, busy
  );
endinterface

// File: rtl/round_sequencer.sv
// Sequences one guessing game: fetch a target, time the guess window, judge,
// strobe the score counters and hold the feedback tone request.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; mode_sel latched on exit
// S_FETCH | rand_req high until rand_valid delivers the target
// S_PLAY  | guess window open for ROUND_TICKS cycles
// S_JUDGE | single cycle: score_we strobe with hit/miss
// S_SOUND | tone request until ack, at least FEEDBACK_TICKS cycles
// S_DONE  | game over; leaves when start drops
module round_sequencer #(
  parameter int ROUND_TICKS    = 500_000_000,
  parameter int FEEDBACK_TICKS = 50_000_000,
  parameter int NUM_ROUNDS     = 10,
  parameter int CNT_W          = 32
) (
  input  logic              clock,
  input  logic              reset,
  round_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PLAY  = 3'd2,
    S_JUDGE = 3'd3,
    S_SOUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUND_TICKS - 1);
  localparam logic [CNT_W-1:0] FB_LAST    = CNT_W'(FEEDBACK_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = '1;
  localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0]       END_ROUND  = 4'(NUM_ROUNDS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [3:0]       target, target_nxt;
  logic [3:0]       guess_latch, guess_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [3:0]       round_q, round_nxt;
  logic             sel_q, sel_nxt;
  logic             ack_seen, ack_nxt;
  logic             ack_now;

  logic rand_req_q, window_q, we_q, hit_q, snd_req_q, done_q, busy_q;

  assign ack_now = ack_seen | bus.snd_ack;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);
    target_nxt = target;
    guess_nxt  = guess_latch;
    mode_nxt   = mode_q;
    round_nxt  = round_q;
    sel_nxt    = sel_q;
    ack_nxt    = ack_seen;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          mode_nxt  = (bus.gameMode == 2'b00) ? 2'b01 : bus.gameMode;
          round_nxt = 4'd0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!bus.start) begin
          state_nxt = S_IDLE;
        end else if (bus.rand_valid) begin
          target_nxt = bus.randValue;
          timer_nxt  = '0;
          state_nxt  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!bus.start) begin
          state_nxt = S_IDLE;
        end else if (timer == ROUND_LAST) begin
          guess_nxt = bus.userGuess;
          state_nxt = S_JUDGE;
        end
      end
      S_JUDGE: begin
        // The strobe for this cycle is already out; an abort lands next cycle.
        sel_nxt   = (guess_latch != target);
        timer_nxt = '0;
        ack_nxt   = 1'b0;
        state_nxt = bus.start ? S_SOUND : S_IDLE;
      end
      S_SOUND: begin
        if (!bus.start) begin
          state_nxt = S_IDLE;
        end else begin
          ack_nxt = ack_now;
          if (ack_now && (timer >= FB_LAST)) begin
            if (round_q == LAST_ROUND) begin
              round_nxt = END_ROUND;
              state_nxt = S_DONE;
            end else begin
              round_nxt = round_q + 4'd1;
              state_nxt = S_FETCH;
            end
          end
        end
      end
      S_DONE: begin
        if (!bus.start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      target      <= '0;
      guess_latch <= '0;
      mode_q      <= '0;
      round_q     <= '0;
      sel_q       <= 1'b0;
      ack_seen    <= 1'b0;
      rand_req_q  <= 1'b0;
      window_q    <= 1'b0;
      we_q        <= 1'b0;
      hit_q       <= 1'b0;
      snd_req_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      target      <= target_nxt;
      guess_latch <= guess_nxt;
      mode_q      <= mode_nxt;
      round_q     <= round_nxt;
      sel_q       <= sel_nxt;
      ack_seen    <= ack_nxt;
      rand_req_q  <= (state_nxt == S_FETCH);
      window_q    <= (state_nxt == S_PLAY);
      we_q        <= (state_nxt == S_JUDGE);
      hit_q       <= (state_nxt == S_JUDGE) && (guess_nxt == target);
      snd_req_q   <= (state_nxt == S_SOUND) && !ack_nxt;
      done_q      <= (state_nxt == S_DONE);
      busy_q      <= (state_nxt == S_FETCH) || (state_nxt == S_PLAY) ||
                     (state_nxt == S_JUDGE) || (state_nxt == S_SOUND);
    end
  end

  assign bus.rand_req     = rand_req_q;
  assign bus.mode_sel     = mode_q;
  assign bus.guess_window = window_q;
  assign bus.score_we     = we_q;
  assign bus.score_hit    = hit_q;
  assign bus.snd_req      = snd_req_q;
  assign bus.snd_sel      = sel_q;
  assign bus.round_num    = round_q;
  assign bus.game_done    = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a cycle table for reset and the first round,
// then hand-written sequences for ack timing, full game, abort and stray rand_valid.
module tb_round_sequencer;
  localparam int RT = 8;
  localparam int FB = 4;
  localparam int NR = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   we_count = 0;

  round_sequencer_if bus ();

  round_sequencer #(
    .ROUND_TICKS(RT), .FEEDBACK_TICKS(FB), .NUM_ROUNDS(NR), .CNT_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (bus.score_we === 1'b1) we_count++;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  guess;
    logic [3:0]  rval;
    logic        rvalid;
    logic        ack;
    logic [13:0] exp;
  } vec_t;

  vec_t vq[$];

  // {rand_req, guess_window, score_we, score_hit, snd_req, snd_sel, round_num, game_done, busy, mode_sel}
  function automatic logic [13:0] e(input logic rr, gw, we, hit, sr, ss,
                                    input logic [3:0] rn, input logic dn, bz,
                                    input logic [1:0] ms);
    return {rr, gw, we, hit, sr, ss, rn, dn, bz, ms};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.rand_req, bus.guess_window, bus.score_we, bus.score_hit, bus.snd_req,
            bus.snd_sel, bus.round_num, bus.game_done, bus.busy, bus.mode_sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic add(input logic rst, st, input logic [1:0] m, input logic [3:0] g, rv,
                     input logic rvd, ak, input logic [13:0] ex);
    vec_t v;
    v.rst = rst; v.start = st; v.mode = m; v.guess = g; v.rval = rv;
    v.rvalid = rvd; v.ack = ak; v.exp = ex;
    vq.push_back(v);
  endtask

  initial begin
    int n;
    int we_base;

    bus.start = 1'b1; bus.gameMode = 2'b00; bus.userGuess = 4'h0;
    bus.randValue = 4'h0; bus.rand_valid = 1'b0; bus.snd_ack = 1'b0;

    // Reset, release, abort from FETCH, restart in hex, then round 0 with a hit.
    add(1, 1, 2'b00, 4'h0, 4'h0, 0, 0, e(0,0,0,0,0,0,4'd0,0,0,2'd0));
    add(1, 1, 2'b00, 4'h0, 4'h0, 0, 0, e(0,0,0,0,0,0,4'd0,0,0,2'd0));
    add(0, 1, 2'b00, 4'h0, 4'h0, 0, 0, e(1,0,0,0,0,0,4'd0,0,1,2'd1));
    add(0, 0, 2'b00, 4'h0, 4'h0, 0, 0, e(0,0,0,0,0,0,4'd0,0,0,2'd1));
    add(0, 1, 2'b10, 4'h0, 4'h0, 0, 0, e(1,0,0,0,0,0,4'd0,0,1,2'd2));
    add(0, 1, 2'b10, 4'hA, 4'hA, 1, 0, e(0,1,0,0,0,0,4'd0,0,1,2'd2));
    for (int k = 0; k < 7; k++)
      add(0, 1, 2'b10, 4'hA, 4'h0, 0, 0, e(0,1,0,0,0,0,4'd0,0,1,2'd2));
    add(0, 1, 2'b10, 4'hA, 4'h0, 0, 0, e(0,0,1,1,0,0,4'd0,0,1,2'd2));
    add(0, 1, 2'b10, 4'hA, 4'h0, 0, 0, e(0,0,0,0,1,0,4'd0,0,1,2'd2));
    add(0, 1, 2'b10, 4'hA, 4'h0, 0, 1, e(0,0,0,0,0,0,4'd0,0,1,2'd2));
    add(0, 1, 2'b10, 4'hA, 4'h0, 0, 0, e(0,0,0,0,0,0,4'd0,0,1,2'd2));
    add(0, 1, 2'b10, 4'hA, 4'h0, 0, 0, e(0,0,0,0,0,0,4'd0,0,1,2'd2));
    add(0, 1, 2'b10, 4'hA, 4'h0, 0, 0, e(1,0,0,0,0,0,4'd1,0,1,2'd2));

    we_base = we_count;
    foreach (vq[i]) begin
      reset = vq[i].rst; bus.start = vq[i].start; bus.gameMode = vq[i].mode;
      bus.userGuess = vq[i].guess; bus.randValue = vq[i].rval;
      bus.rand_valid = vq[i].rvalid; bus.snd_ack = vq[i].ack;
      cyc();
      check($sformatf("vec%0d", i), 32'(observed()), 32'(vq[i].exp));
    end

    // Round 1: FETCH waits 5 cycles, miss, ack on the 6th SOUND cycle.
    bus.rand_valid = 1'b0; bus.snd_ack = 1'b0; bus.userGuess = 4'h5;
    for (int k = 2; k <= 5; k++) begin
      cyc();
      check("fetch_wait_req", 32'(bus.rand_req), 32'd1);
    end
    bus.rand_valid = 1'b1; bus.randValue = 4'hA;
    cyc();
    bus.rand_valid = 1'b0;
    n = bus.guess_window ? 1 : 0;
    for (int b = 0; b < 20 && bus.guess_window; b++) begin
      cyc();
      if (bus.guess_window) n++;
    end
    check("r1_window_len", 32'(n), 32'd8);
    check("r1_judge", 32'({bus.score_we, bus.score_hit}), 32'b10);
    cyc();
    check("r1_sound_entry", 32'({bus.snd_req, bus.snd_sel}), 32'b11);
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("r1_sound_c%0d", k), 32'({bus.snd_req, bus.rand_req, bus.busy}), 32'b101);
      bus.snd_ack = (k == 6);
      bus.rand_valid = (k == 3); bus.randValue = 4'h3;
      cyc();
    end
    bus.snd_ack = 1'b0; bus.rand_valid = 1'b0;
    check("r1_exit_fetch", 32'({bus.rand_req, bus.snd_req}), 32'b10);
    check("r1_round_num", 32'(bus.round_num), 32'd2);

    // Round 2: rand_valid on the FETCH entry cycle, stray rand_valid in PLAY, ack at SOUND entry.
    bus.rand_valid = 1'b1; bus.randValue = 4'hA; bus.userGuess = 4'hA;
    cyc();
    bus.rand_valid = 1'b0;
    check("r2_play_entry", 32'(bus.guess_window), 32'd1);
    cyc();
    bus.rand_valid = 1'b1; bus.randValue = 4'h3;
    cyc();
    bus.rand_valid = 1'b0;
    for (int b = 0; b < 20 && bus.guess_window; b++) cyc();
    check("r2_target_kept", 32'({bus.score_we, bus.score_hit}), 32'b11);
    cyc();
    check("r2_sound_sel", 32'({bus.snd_req, bus.snd_sel}), 32'b10);
    n = 0;
    bus.snd_ack = 1'b1;
    for (int b = 0; b < 20 && bus.busy && !bus.rand_req; b++) begin
      n++;
      cyc();
      bus.snd_ack = 1'b0;
    end
    check("r2_sound_len", 32'(n), 32'd4);
    check("done_state", 32'({bus.game_done, bus.busy}), 32'b10);
    check("done_round_num", 32'(bus.round_num), 32'd3);
    check("score_pulses", 32'(we_count - we_base), 32'd3);

    for (int k = 0; k < 3; k++) begin
      cyc();
      check("done_hold", 32'({bus.game_done, bus.rand_req}), 32'b10);
    end
    bus.start = 1'b0;
    cyc();
    check("done_to_idle", 32'({bus.game_done, bus.busy}), 32'b00);
    check("idle_round_num", 32'(bus.round_num), 32'd3);

    // Abort on PLAY cycle 3; gameMode changes mid-game must not reach mode_sel.
    bus.start = 1'b1; bus.gameMode = 2'b11;
    cyc();
    check("octal_mode", 32'(bus.mode_sel), 32'd3);
    check("new_game_round", 32'(bus.round_num), 32'd0);
    bus.rand_valid = 1'b1; bus.randValue = 4'h7; bus.userGuess = 4'h7;
    cyc();
    bus.rand_valid = 1'b0; bus.gameMode = 2'b01;
    cyc();
    cyc();
    check("abort_play3", 32'({bus.guess_window, bus.mode_sel}), 32'b111);
    we_base = we_count;
    bus.start = 1'b0;
    cyc();
    check("abort_idle", 32'(observed()), 32'(e(0,0,0,0,0,0,4'd0,0,0,2'd3)));
    cyc();
    cyc();
    check("abort_no_we", 32'(we_count - we_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
